mem_stage: RTL and testbench

//  Pipeline stage directly downstream of EX: holds the EX/MEM register and runs the data-memory

---
 rtl/mem_stage_pkg.sv | 54 +++++
 rtl/mem_stage_align.sv | 55 +++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode/funct3 codes, FSM encoding and EX/MEM payload for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned FN_W  = 3;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;

  localparam logic [FN_W-1:0] FN_LB  = 3'b000;
  localparam logic [FN_W-1:0] FN_LH  = 3'b001;
  localparam logic [FN_W-1:0] FN_LW  = 3'b010;
  localparam logic [FN_W-1:0] FN_LBU = 3'b100;
  localparam logic [FN_W-1:0] FN_LHU = 3'b101;
  localparam logic [FN_W-1:0] FN_SB  = 3'b000;
  localparam logic [FN_W-1:0] FN_SH  = 3'b001;
  localparam logic [FN_W-1:0] FN_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [FN_W-1:0]  func;
    logic [XLEN-1:0]  alu_out;
    logic [XLEN-1:0]  mem_in;
    logic [XLEN-1:0]  data_in;
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } exmem_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Store funct3 codes alias the load codes, so one check covers both.
  function automatic logic is_misaligned(input logic [FN_W-1:0] func, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (func)
      FN_LH, FN_LHU: mis = lo[0];
      FN_LW:         mis = |lo;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store enables/data replication, load lane select/extension, alignment check.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [FN_W-1:0] func_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] lane;

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    case (func_i[1:0])
      FN_SB[1:0]: begin
        be_o    = BE_W'(4'b0001 << addr_lo_i);
        wdata_o = {4{st_data_i[7:0]}};
      end
      FN_SH[1:0]: begin
        be_o    = BE_W'(4'b0011 << addr_lo_i);
        wdata_o = {2{st_data_i[15:0]}};
      end
      FN_SW[1:0]: begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
      default: begin
        be_o    = '0;
        wdata_o = '0;
      end
    endcase
  end

  always_comb begin
    lane        = rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = rdata_i;
    case (func_i)
      FN_LB:   load_data_o = {{24{lane[7]}}, lane[7:0]};
      FN_LH:   load_data_o = {{16{lane[15]}}, lane[15:0]};
      FN_LW:   load_data_o = rdata_i;
      FN_LBU:  load_data_o = {24'h0, lane[7:0]};
      FN_LHU:  load_data_o = {16'h0, lane[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

  assign misaligned_o = is_misaligned(func_i, addr_lo_i);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake with timeout, MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [FN_W-1:0]   ex_func,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic [XLEN-1:0]   ex_mem_in,
  input  logic [XLEN-1:0]   ex_data_in,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  output logic              mem_stall,
  output logic [XLEN-1:0]   m_data_hzd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_regwrite,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign_exc,
  output logic              bus_err
);

  exmem_t           ex_d, ex_q;
  logic             valid_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;

  logic [BE_W-1:0]  be_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  load_data_c;
  logic             misaligned_c;
  logic             is_load_c, is_store_c, mis_exc_c;

  logic             wb_valid_q, wb_regwrite_q, misalign_q, bus_err_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;

  always_comb begin
    ex_d          = '0;
    ex_d.opcode   = ex_opcode;
    ex_d.func     = ex_func;
    ex_d.alu_out  = ex_alu_out;
    ex_d.mem_in   = ex_mem_in;
    ex_d.data_in  = ex_data_in;
    ex_d.rd       = ex_rd;
    ex_d.regwrite = ex_regwrite;
  end

  mem_align u_align (
    .func_i       (ex_q.func),
    .addr_lo_i    (ex_q.alu_out[1:0]),
    .st_data_i    (ex_q.mem_in),
    .rdata_i      (dmem_rdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .load_data_o  (load_data_c),
    .misaligned_o (misaligned_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ACCESS is entered at the capture edge so dmem_req rises in the op's first MEM cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_ACCESS: begin
        if (!dmem_ready) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_c = 1'b1;
          end else begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!mem_stall) begin
      cnt_d   = '0;
      state_d = (ex_valid && is_mem_op(ex_opcode) && !is_misaligned(ex_func, ex_alu_out[1:0]))
                ? ST_ACCESS : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (!mem_stall) begin
      valid_q <= ex_valid;
      ex_q    <= ex_d;
    end
  end

  assign is_load_c  = ex_q.opcode == OP_LOAD;
  assign is_store_c = ex_q.opcode == OP_STORE;
  assign mis_exc_c  = valid_q && (is_load_c || is_store_c) && misaligned_c;

  // A stalled MEM op leaves a bubble in WB so each retire is a single-cycle event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= '0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else if (mem_stall) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      wb_valid_q    <= valid_q;
      wb_rd_q       <= ex_q.rd;
      wb_regwrite_q <= valid_q && ex_q.regwrite && !is_store_c && !mis_exc_c && !timeout_c;
      wb_data_q     <= is_load_c ? load_data_c : ex_q.data_in;
      misalign_q    <= mis_exc_c;
      bus_err_q     <= timeout_c;
    end
  end

  assign dmem_req     = state_q == ST_ACCESS;
  assign dmem_we      = dmem_req && is_store_c;
  assign dmem_addr    = {ex_q.alu_out[XLEN-1:2], 2'b00};
  assign dmem_be      = dmem_req ? be_c : '0;
  assign dmem_wdata   = wdata_c;
  assign m_data_hzd   = ex_q.data_in;

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_data      = wb_data_q;
  assign misalign_exc = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: memory responder with programmable wait states, WB monitor.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TO = 15;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic        clk, rst_n;
  logic        ex_valid, ex_regwrite;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func;
  logic [31:0] ex_alu_out, ex_mem_in, ex_data_in;
  logic [4:0]  ex_rd;
  logic        mem_stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] m_data_hzd, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_regwrite, misalign_exc, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func(ex_func),
    .ex_alu_out(ex_alu_out), .ex_mem_in(ex_mem_in), .ex_data_in(ex_data_in), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .mem_stall(mem_stall), .m_data_hzd(m_data_hzd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        mis;
    logic        err;
  } wb_t;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference WB result, written per lane rather than by shifting.
  function automatic wb_t model(input logic [6:0] op, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] rdata, input logic [31:0] dd,
                                input logic [4:0] rd, input logic rw, input bit to);
    wb_t e;
    logic [7:0]  b;
    logic [15:0] h;
    e.rd = rd; e.rw = rw; e.data = dd; e.mis = 1'b0; e.err = 1'b0;
    if (op == OP_LOAD || op == OP_STORE) begin
      case (f)
        3'd1, 3'd5: e.mis = a[0];
        3'd2:       e.mis = (a[1:0] != 2'b00);
        default:    e.mis = 1'b0;
      endcase
      e.err = !e.mis && to;
      if (op == OP_STORE || e.mis || to) e.rw = 1'b0;
      case (a[1:0])
        2'd0:    b = rdata[7:0];
        2'd1:    b = rdata[15:8];
        2'd2:    b = rdata[23:16];
        default: b = rdata[31:24];
      endcase
      h = a[1] ? rdata[31:16] : rdata[15:0];
      if (op == OP_LOAD) begin
        case (f)
          3'd0:    e.data = {{24{b[7]}}, b};
          3'd1:    e.data = {{16{h[15]}}, h};
          3'd4:    e.data = {24'h0, b};
          3'd5:    e.data = {16'h0, h};
          default: e.data = rdata;
        endcase
      end
    end
    return e;
  endfunction

  // Memory responder: ready after mem_waits wait cycles; checks bus fields on first req cycle.
  int          mem_waits = 0;
  logic [31:0] mem_rdata = '0;
  int          w = 0;
  int          req_cnt = 0;
  bit          chk_bus = 0;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata, last_wdata;
  logic [3:0]  exp_be, last_be;

  initial begin
    dmem_ready = 1'b0;
    dmem_rdata = '0;
  end

  always @(negedge clk) begin
    if (!dmem_req) begin
      dmem_ready = 1'b0;
      w = 0;
    end else begin
      req_cnt++;
      if (chk_bus) begin
        chk_bus = 0;
        last_be = dmem_be;
        last_wdata = dmem_wdata;
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        check("dmem_addr", dmem_addr, exp_addr);
        if (exp_we) begin
          check("dmem_be", 32'(dmem_be), 32'(exp_be));
          check("dmem_wdata", dmem_wdata, exp_wdata);
        end
      end
      if (dmem_ready) begin
        dmem_ready = 1'b0;
        w = 0;
      end else if (w >= mem_waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = mem_rdata;
      end else begin
        w++;
        dmem_rdata = $urandom;
      end
    end
  end

  wb_t         mon_e;
  logic [31:0] last_wb_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          last_wb_data = wb_data;
          check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
          check("wb_regwrite", 32'(wb_regwrite), 32'(mon_e.rw));
          check("misalign_exc", 32'(misalign_exc), 32'(mon_e.mis));
          check("bus_err", 32'(bus_err), 32'(mon_e.err));
          if (mon_e.rw) check("wb_data", wb_data, mon_e.data);
        end
      end else begin
        check("idle_pulses", 32'({misalign_exc, bus_err, wb_regwrite}), 32'd0);
      end
    end
  end

  task automatic do_op(input logic [6:0] op, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] dd, input logic [4:0] rd,
                       input logic rw, input int waits, input logic [31:0] rdata,
                       input bit follow, output int stalls, output int reqs);
    wb_t e;
    bit  fpend;
    e = model(op, f, a, rdata, dd, rd, rw, waits >= 1000);
    @(negedge clk); #1;
    ex_valid = 1'b1; ex_opcode = op; ex_func = f; ex_alu_out = a;
    ex_mem_in = sd; ex_data_in = dd; ex_rd = rd; ex_regwrite = rw;
    mem_waits = waits; mem_rdata = rdata; req_cnt = 0;
    exp_we = (op == OP_STORE);
    exp_addr = {a[31:2], 2'b00};
    exp_be = 4'b0000;
    case (f[1:0])
      2'd0: begin exp_be[a[1:0]] = 1'b1; exp_wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]}; end
      2'd1: begin exp_be[a[1:0]] = 1'b1; exp_be[a[1:0] + 2'd1] = 1'b1;
                  exp_wdata = {sd[15:0], sd[15:0]}; end
      default: begin exp_be = 4'hF; exp_wdata = sd; end
    endcase
    chk_bus = (op == OP_LOAD || op == OP_STORE) && !e.mis;
    sb.push_back(e);
    @(posedge clk); #1;
    fpend = 0;
    if (follow) begin
      ex_opcode = OP_ALU; ex_func = 3'd0; ex_data_in = dd ^ 32'hF00D_0000;
      ex_rd = rd + 5'd1; ex_regwrite = 1'b1;
      sb.push_back(model(OP_ALU, 3'd0, a, rdata, dd ^ 32'hF00D_0000, rd + 5'd1, 1'b1, 0));
      fpend = 1;
    end else begin
      ex_valid = 1'b0;
    end
    stalls = 0;
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
      if (mem_stall) begin
        stalls++;
        check("hzd_hold", m_data_hzd, dd);
      end
      if (fpend && !mem_stall) begin
        @(posedge clk); #1;
        ex_valid = 1'b0;
        fpend = 0;
      end
    end
    ex_valid = 1'b0;
    if (sb.size() != 0) begin
      check("wb_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    if (chk_bus) begin
      check("req_seen", 32'(chk_bus), 32'd0);
      chk_bus = 0;
    end
    reqs = req_cnt;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int st, rq;
  logic [6:0] r_op;
  logic [2:0] r_f;

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_func = '0; ex_alu_out = '0;
    ex_mem_in = '0; ex_data_in = '0; ex_rd = '0; ex_regwrite = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_hzd", m_data_hzd, 32'd0);
    check("rst_pulses", 32'({misalign_exc, bus_err, wb_regwrite}), 32'd0);
    rst_n = 1'b1;

    do_op(OP_STORE, FN_SW, 32'h100, 32'hDEADBEEF, 32'h11, 5'd3, 1'b1, 0, 32'h0, 0, st, rq);
    check("t1_stall", 32'(st), 32'd0);
    check("t1_be", 32'(last_be), 32'hF);
    check("t1_wdata", last_wdata, 32'hDEADBEEF);

    do_op(OP_LOAD, FN_LB, 32'h103, 32'h0, 32'h22, 5'd4, 1'b1, 0, 32'h80FF_FF7F, 0, st, rq);
    check("t2_lb", last_wb_data, 32'hFFFF_FF80);
    do_op(OP_LOAD, FN_LBU, 32'h103, 32'h0, 32'h23, 5'd5, 1'b1, 0, 32'h80FF_FF7F, 0, st, rq);
    check("t2_lbu", last_wb_data, 32'h0000_0080);

    do_op(OP_LOAD, FN_LH, 32'h102, 32'h0, 32'h33, 5'd6, 1'b1, 3, 32'h8001_1234, 1, st, rq);
    check("t3_stalls", 32'(st), 32'd3);
    check("t3_reqs", 32'(rq), 32'd4);

    do_op(OP_LOAD, FN_LW, 32'h101, 32'h0, 32'h44, 5'd7, 1'b1, 0, 32'h1234_5678, 0, st, rq);
    check("t4_no_req", 32'(rq), 32'd0);

    do_op(OP_LOAD, FN_LW, 32'h200, 32'h0, 32'h55, 5'd8, 1'b1, 1000, 32'h0, 0, st, rq);
    check("t5_req_cycles", 32'(rq), 32'(TO));
    check("t5_stalls", 32'(st), 32'(TO - 1));
    check("t5_stall_rel", 32'(mem_stall), 32'd0);

    // Reset while an access is outstanding abandons it without a WB retire.
    @(negedge clk); #1;
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_func = FN_LW; ex_alu_out = 32'h400;
    ex_rd = 5'd9; ex_regwrite = 1'b1; mem_waits = 1000;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_req_drop", 32'(dmem_req), 32'd0);
    check("t6_wb_valid", 32'(wb_valid), 32'd0);
    check("t6_stall", 32'(mem_stall), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    do_op(OP_STORE, FN_SB, 32'h202, 32'h1234_56A5, 32'h66, 5'd10, 1'b1, 1, 32'h0, 0, st, rq);
    check("sb_be", 32'(last_be), 32'h4);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    do_op(OP_STORE, FN_SH, 32'h306, 32'h0000_BEEF, 32'h77, 5'd11, 1'b0, 2, 32'h0, 1, st, rq);
    check("sh_be", 32'(last_be), 32'hC);
    do_op(OP_LOAD, FN_LHU, 32'h102, 32'h0, 32'h88, 5'd12, 1'b1, 0, 32'h8001_1234, 0, st, rq);
    check("lhu_data", last_wb_data, 32'h0000_8001);
    do_op(OP_ALU, 3'd0, 32'h5, 32'h0, 32'hCAFE_F00D, 5'd13, 1'b1, 0, 32'h0, 0, st, rq);
    check("alu_data", last_wb_data, 32'hCAFE_F00D);
    do_op(OP_STORE, FN_SW, 32'h30A, 32'h1, 32'h99, 5'd14, 1'b0, 0, 32'h0, 0, st, rq);
    check("sw_mis_no_req", 32'(rq), 32'd0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(2, 0))
        0: r_op = OP_LOAD;
        1: r_op = OP_STORE;
        default: r_op = OP_ALU;
      endcase
      case ($urandom_range(4, 0))
        0: r_f = 3'd0;
        1: r_f = 3'd1;
        2: r_f = 3'd2;
        3: r_f = 3'd4;
        default: r_f = 3'd5;
      endcase
      if (r_op == OP_STORE && r_f[2]) r_f = {1'b0, r_f[1:0]};
      do_op(r_op, r_f, $urandom, $urandom, $urandom, 5'($urandom_range(30, 1)),
            1'($urandom), $urandom_range(3, 0), $urandom, 1'($urandom), st, rq);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
